// File: rtl/eth_dma_tx_ring_master_pkg.sv
// ============================================================================
// Module : eth_dma_tx_ring_master_pkg
// Desc   : Shared TX ring types, master FSM states and MAC header-tag helper.
// Rev    : 1.0  initial parametrised multi-PID release
// ============================================================================
`default_nettype none

package eth_dma_tx_ring_master_pkg;

  localparam int c_pid_w    = 3;
  localparam int c_npid_max = 1 << c_pid_w;

  typedef enum logic [2:0] {
    tx_none        = 3'd0,
    tx_start_empty = 3'd1,
    tx_start       = 3'd2,
    slot_start     = 3'd3,
    tx_data        = 3'd4,
    tx_end         = 3'd5
  } eth_tx_stype_t;

  typedef struct packed {
    logic [c_pid_w-1:0] pid;
    logic [12:0]        len;
  } eth_tx_header_t;

  typedef struct packed {
    eth_tx_header_t header;
    logic [31:0]    payload;
  } eth_tx_msg_t;

  typedef struct packed {
    eth_tx_stype_t stype;
    eth_tx_msg_t   msg;
  } eth_tx_ring_data_type;

  typedef enum logic [1:0] {
    S_WAIT_START = 2'd0,
    S_WAIT_DONE  = 2'd1,
    S_HOLD       = 2'd2,
    S_FLUSH      = 2'd3
  } eth_tx_master_state_t;

  localparam logic [3:0] c_default_mac_pid_mask = 4'b0001;

  // Start beats from masked PIDs are promoted to tx_start; all other tx_start become slot_start.
  function automatic eth_tx_stype_t tag_stype(input eth_tx_stype_t      stype,
                                              input logic [c_pid_w-1:0] pid,
                                              input int                 npid,
                                              input logic [c_npid_max-1:0] mask);
    logic hit;
    hit = (int'(pid) < npid) && mask[pid];
    if ((stype == tx_start || stype == slot_start) && hit) return tx_start;
    if (stype == tx_start && !hit) return slot_start;
    return stype;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_dma_tx_ring_master_counters.sv
// ============================================================================
// Module : eth_tx_pid_counters
// Desc   : Per-PID wrapping frame counters, packed PID p at [p*CNT_W +: CNT_W].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_tx_pid_counters
  import eth_dma_tx_ring_master_pkg::*;
#(
  parameter int NPID  = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic [c_pid_w-1:0]      i_pid,
  output logic [NPID*CNT_W-1:0]   o_frames_sent
);

  generate
    for (genvar p = 0; p < NPID; p++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (i_en && (i_pid == c_pid_w'(p))) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_frames_sent[p*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/eth_dma_tx_ring_master.sv
// ============================================================================
// Module : eth_dma_tx_ring_master
// Desc   : TX ring master: forwards returning frames to the MAC, reissues token.
// Rev    : 1.0  multi-PID, back-pressure, watchdog and frame-timeout release
// ============================================================================
`default_nettype none

module eth_dma_tx_ring_master
  import eth_dma_tx_ring_master_pkg::*;
#(
  parameter int              NPID          = 4,
  parameter logic [NPID-1:0] MAC_PID_MASK  = NPID'(c_default_mac_pid_mask),
  parameter int              TOKEN_TIMEOUT = 1024,
  parameter int              FRAME_TIMEOUT = 4096,
  parameter int              FLUSH_CYCLES  = 16,
  parameter int              CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  eth_tx_ring_data_type  tx_ring_in,
  input  logic                  mac_tx_ready,
  output eth_tx_ring_data_type  tx_to_mac,
  output eth_tx_ring_data_type  tx_ring_out,
  output logic                  token_regen,
  output logic                  timeout_err,
  output logic [NPID*CNT_W-1:0] frames_sent
);

  localparam int c_wd_w = $clog2(TOKEN_TIMEOUT + 1);
  localparam int c_fr_w = $clog2(FRAME_TIMEOUT + 1);
  localparam int c_fl_w = $clog2(FLUSH_CYCLES + 1);
  localparam logic [c_npid_max-1:0] c_mask_ext = c_npid_max'(MAC_PID_MASK);

  eth_tx_master_state_t r_state, w_state_nxt;
  logic [c_wd_w-1:0]    r_wdog, w_wdog_nxt;
  logic [c_fr_w-1:0]    r_frame, w_frame_nxt;
  logic [c_fl_w-1:0]    r_flush, w_flush_nxt, w_flush_inc;
  eth_tx_stype_t        w_ring_stype;
  eth_tx_ring_data_type w_mac;
  logic                 w_regen, w_terr;
  logic                 w_is_none, w_is_token, w_is_beat, w_is_start, w_cnt_en;

  assign w_is_none   = (tx_ring_in.stype == tx_none);
  assign w_is_token  = (tx_ring_in.stype == tx_start_empty);
  assign w_is_beat   = !w_is_none && !w_is_token;
  assign w_is_start  = (tx_ring_in.stype == tx_start) || (tx_ring_in.stype == slot_start);
  assign w_cnt_en    = w_is_start && (r_state != S_FLUSH);
  assign w_flush_inc = r_flush + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_wdog_nxt   = r_wdog;
    w_frame_nxt  = r_frame;
    w_flush_nxt  = '0;
    w_ring_stype = tx_none;
    w_regen      = 1'b0;
    w_terr       = 1'b0;
    case (r_state)
      S_WAIT_START: begin
        if (w_is_beat) begin
          w_state_nxt = S_WAIT_DONE;
          w_frame_nxt = '0;
        end else if (w_is_token) begin
          w_ring_stype = tx_start_empty;
          w_wdog_nxt   = '0;
        end else if (r_wdog == c_wd_w'(TOKEN_TIMEOUT - 1)) begin
          w_ring_stype = tx_start_empty;
          w_regen      = 1'b1;
          w_wdog_nxt   = '0;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        w_frame_nxt = r_frame + 1'b1;
        // Frame completion is checked first so it beats a coincident timeout.
        if (w_is_none) begin
          if (mac_tx_ready) begin
            w_ring_stype = tx_start_empty;
            w_state_nxt  = S_WAIT_START;
            w_wdog_nxt   = '0;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else if (r_frame == c_fr_w'(FRAME_TIMEOUT - 1)) begin
          w_terr      = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (mac_tx_ready && w_is_none) begin
          w_ring_stype = tx_start_empty;
          w_state_nxt  = S_WAIT_START;
          w_wdog_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (w_is_none) begin
          w_flush_nxt = w_flush_inc;
          if (w_flush_inc == c_fl_w'(FLUSH_CYCLES)) w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_WAIT_DONE;
    endcase
  end

  always_comb begin
    w_mac       = tx_ring_in;
    w_mac.stype = tag_stype(tx_ring_in.stype, tx_ring_in.msg.header.pid, NPID, c_mask_ext);
    if (r_state == S_FLUSH) w_mac = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT_DONE;
      r_wdog      <= '0;
      r_frame     <= '0;
      r_flush     <= '0;
      tx_ring_out <= '0;
      tx_to_mac   <= '0;
      token_regen <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_wdog            <= w_wdog_nxt;
      r_frame           <= w_frame_nxt;
      r_flush           <= w_flush_nxt;
      tx_ring_out.stype <= w_ring_stype;
      tx_ring_out.msg   <= '0;
      tx_to_mac         <= w_mac;
      token_regen       <= w_regen;
      timeout_err       <= w_terr;
    end
  end

  eth_tx_pid_counters #(
    .NPID  (NPID),
    .CNT_W (CNT_W)
  ) u_counters (
    .clk           (clk),
    .reset         (reset),
    .i_en          (w_cnt_en),
    .i_pid         (tx_ring_in.msg.header.pid),
    .o_frames_sent (frames_sent)
  );

endmodule

`default_nettype wire

// File: tb/tb_eth_dma_tx_ring_master.sv
// ============================================================================
// Module : tb_eth_dma_tx_ring_master
// Desc   : Directed scoreboard bench for the TX ring master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eth_dma_tx_ring_master;
  import eth_dma_tx_ring_master_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  eth_tx_ring_data_type ring_in;
  logic                 ready;
  eth_tx_ring_data_type tx_to_mac;
  eth_tx_ring_data_type ring_out;
  logic                 token_regen;
  logic                 timeout_err;
  logic [63:0]          frames_sent;

  eth_dma_tx_ring_master #(
    .NPID          (4),
    .MAC_PID_MASK  (4'b0001),
    .TOKEN_TIMEOUT (1024),
    .FRAME_TIMEOUT (64),
    .FLUSH_CYCLES  (16),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_ring_in   (ring_in),
    .mac_tx_ready (ready),
    .tx_to_mac    (tx_to_mac),
    .tx_ring_out  (ring_out),
    .token_regen  (token_regen),
    .timeout_err  (timeout_err),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    eth_tx_stype_t stype;
    logic [2:0]    pid;
    int            t;
  } exp_beat_t;

  exp_beat_t mac_q[$];
  int        ring_q[$];
  int        regen_q[$];
  int        terr_q[$];
  int        vectors = 0;
  int        miscompares = 0;
  int        t_now = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_extra(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output seen at cycle %0d, none expected", name, cyc);
  endtask

  // Drive one input beat; t_now is the cycle its response is due on the outputs.
  task automatic send(input eth_tx_stype_t s, input logic [2:0] pid, input logic rdy,
                      input eth_tx_stype_t mac_exp, input logic ring_tok);
    @(negedge clk);
    ring_in.stype           = s;
    ring_in.msg.header.pid  = pid;
    ring_in.msg.header.len  = 13'd64;
    ring_in.msg.payload     = $urandom;
    ready                   = rdy;
    t_now                   = cyc + 1;
    if (mac_exp != tx_none) mac_q.push_back('{mac_exp, pid, t_now});
    if (ring_tok) ring_q.push_back(t_now);
  endtask

  task automatic token_back();
    send(tx_start_empty, 3'd0, 1'b1, tx_start_empty, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ring_out.stype != tx_none) begin
        check("ring_stype", 64'(ring_out.stype), 64'(tx_start_empty));
        check("ring_msg", 64'(ring_out.msg), 64'd0);
        if (ring_q.size() == 0) flag_extra("ring_token");
        else check("ring_token_cycle", 64'(cyc), 64'(ring_q.pop_front()));
      end
      if (tx_to_mac.stype != tx_none) begin
        if (mac_q.size() == 0) flag_extra("mac_beat");
        else begin
          exp_beat_t e;
          e = mac_q.pop_front();
          check("mac_stype", 64'(tx_to_mac.stype), 64'(e.stype));
          check("mac_pid", 64'(tx_to_mac.msg.header.pid), 64'(e.pid));
          check("mac_cycle", 64'(cyc), 64'(e.t));
        end
      end
      if (token_regen) begin
        if (regen_q.size() == 0) flag_extra("token_regen");
        else check("regen_cycle", 64'(cyc), 64'(regen_q.pop_front()));
      end
      if (timeout_err) begin
        if (terr_q.size() == 0) flag_extra("timeout_err");
        else check("timeout_cycle", 64'(cyc), 64'(terr_q.pop_front()));
      end
    end
  end

  initial begin
    reset   = 1'b1;
    ring_in = '0;
    ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ring_out", 64'(ring_out), 64'd0);
    check("rst_tx_to_mac", 64'(tx_to_mac), 64'd0);
    check("rst_token_regen", 64'(token_regen), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_frames_sent", frames_sent, 64'd0);

    // First tx_none after reset issues the initial token.
    reset   = 1'b0;
    ready   = 1'b1;
    t_now   = cyc + 1;
    ring_q.push_back(t_now);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    token_back();
    token_back();

    // PID 0 frame: masked, so tx_start reaches the MAC.
    send(tx_start, 3'd0, 1'b1, tx_start, 1'b0);
    repeat (6) send(tx_data, 3'd0, 1'b1, tx_data, 1'b0);
    send(tx_end, 3'd0, 1'b1, tx_end, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_pid0_frame", frames_sent, 64'h0000_0000_0000_0001);

    // PID 2 frame: unmasked, tx_start rewritten to slot_start.
    send(tx_start, 3'd2, 1'b1, slot_start, 1'b0);
    repeat (6) send(tx_data, 3'd2, 1'b1, tx_data, 1'b0);
    send(tx_end, 3'd2, 1'b1, tx_end, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_pid2_frame", frames_sent, 64'h0000_0001_0000_0001);

    // MAC back-pressure: frame ends with ready low for 20 cycles.
    send(slot_start, 3'd0, 1'b0, tx_start, 1'b0);
    send(tx_data, 3'd0, 1'b0, tx_data, 1'b0);
    send(tx_end, 3'd0, 1'b0, tx_end, 1'b0);
    repeat (20) send(tx_none, 3'd0, 1'b0, tx_none, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_backpressure", frames_sent, 64'h0000_0001_0000_0002);

    // Watchdog regenerates on the 1024th idle cycle.
    repeat (1023) send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    regen_q.push_back(t_now);
    // A real token on the 1024th cycle wins over regeneration.
    repeat (1023) send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    token_back();

    // Stuck frame: 64th beat in S_WAIT_DONE fires the timeout.
    send(tx_start, 3'd0, 1'b1, tx_start, 1'b0);
    repeat (63) send(tx_data, 3'd0, 1'b1, tx_data, 1'b0);
    send(tx_data, 3'd0, 1'b1, tx_data, 1'b0);
    terr_q.push_back(t_now);
    repeat (3) send(tx_data, 3'd0, 1'b1, tx_none, 1'b0);
    send(slot_start, 3'd0, 1'b1, tx_none, 1'b0);
    repeat (5) send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    send(tx_data, 3'd0, 1'b1, tx_none, 1'b0);
    repeat (16) send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_after_flush", frames_sent, 64'h0000_0001_0000_0003);

    // PID beyond NPID: slot_start to MAC, never counted.
    send(tx_start, 3'd7, 1'b1, slot_start, 1'b0);
    send(tx_end, 3'd7, 1'b1, tx_end, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_pid7", frames_sent, 64'h0000_0001_0000_0003);

    // Drive PID 1 counter to 16'hFFFF by streaming start beats in S_HOLD.
    send(slot_start, 3'd1, 1'b1, slot_start, 1'b0);
    send(tx_none, 3'd0, 1'b0, tx_none, 1'b0);
    repeat (65534) send(tx_start, 3'd1, 1'b0, slot_start, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    check("cnt_pid1_full", frames_sent, 64'h0000_0001_FFFF_0003);
    token_back();
    send(tx_start, 3'd1, 1'b1, slot_start, 1'b0);
    send(tx_end, 3'd1, 1'b1, tx_end, 1'b0);
    send(tx_none, 3'd0, 1'b1, tx_none, 1'b1);
    token_back();
    check("cnt_pid1_wrap", frames_sent, 64'h0000_0001_0000_0003);

    repeat (3) send(tx_none, 3'd0, 1'b1, tx_none, 1'b0);
    check("mac_q_left", 64'(mac_q.size()), 64'd0);
    check("ring_q_left", 64'(ring_q.size()), 64'd0);
    check("regen_q_left", 64'(regen_q.size()), 64'd0);
    check("terr_q_left", 64'(terr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
